// File: rtl/fifo_tx_feeder.sv
// Read-side FIFO consumer: pops one word when the transmitter is free, presents
// it with a valid/busy handshake, and guards the handshake with a watchdog.
module fifo_tx_feeder #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] R_data,
    output logic                  R_inc,
    input  logic                  tx_busy,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_valid,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  byte_cnt
);

    localparam int WDOG_WIDTH = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_WIDTH-1:0] WDOG_LAST = WDOG_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        WAIT_DONE
    } state_t;

    state_t                 state_reg, state_next;
    logic [DATA_WIDTH-1:0]  data_reg,  data_next;
    logic                   valid_reg, valid_next;
    logic                   err_reg,   err_next;
    logic [CNT_WIDTH-1:0]   cnt_reg,   cnt_next;
    logic [WDOG_WIDTH-1:0]  wdog_reg,  wdog_next;
    logic                   pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            err_reg   <= 1'b0;
            cnt_reg   <= '0;
            wdog_reg  <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            err_reg   <= err_next;
            cnt_reg   <= cnt_next;
            wdog_reg  <= wdog_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        valid_next = valid_reg;
        err_next   = err_reg;
        cnt_next   = cnt_reg;
        wdog_next  = wdog_reg;
        pop        = 1'b0;
        case (state_reg)
            IDLE: begin
                // Empty is only looked at here, so a word cannot be popped twice.
                if (enable && !empty && !tx_busy) begin
                    pop        = 1'b1;
                    data_next  = R_data;
                    valid_next = 1'b1;
                    wdog_next  = '0;
                    state_next = PRESENT;
                end
            end
            PRESENT: begin
                if (tx_busy) begin
                    valid_next = 1'b0;
                    state_next = WAIT_DONE;
                end else if (wdog_reg == WDOG_LAST) begin
                    // Transmitter never took the word: drop it, flag, carry on.
                    err_next   = 1'b1;
                    valid_next = 1'b0;
                    state_next = IDLE;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Held low during reset so the FIFO never loses a word the feeder cannot capture.
    assign R_inc       = pop & ~RST;
    assign tx_data     = data_reg;
    assign tx_valid    = valid_reg;
    assign timeout_err = err_reg;
    assign byte_cnt    = cnt_reg;

endmodule

// File: tb/tb_fifo_tx_feeder.sv
// Directed bench for fifo_tx_feeder: FIFO and transmitter models around the DUT,
// a transaction-level reference checked every cycle, plus literal expectations.
module tb_fifo_tx_feeder;

    localparam int DW = 8;
    localparam int TO = 16;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          enable = 1'b0;
    logic          empty;
    logic [DW-1:0] R_data;
    logic          R_inc;
    logic          tx_busy;
    logic [DW-1:0] tx_data;
    logic          tx_valid;
    logic          timeout_err;
    logic [CW-1:0] byte_cnt;

    int vectors = 0;
    int miscompares = 0;

    fifo_tx_feeder #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .empty(empty), .R_data(R_data),
        .R_inc(R_inc), .tx_busy(tx_busy), .tx_data(tx_data), .tx_valid(tx_valid),
        .timeout_err(timeout_err), .byte_cnt(byte_cnt)
    );

    always #5 CLK = ~CLK;

    // FIFO model: words pushed by the stimulus, popped on R_inc.
    logic [DW-1:0] fifo_mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty  = (wr_ptr == rd_ptr);
    assign R_data = fifo_mem[rd_ptr[5:0]];
    always @(posedge CLK) if (R_inc) rd_ptr <= rd_ptr + 1;

    // Transmitter model: accepts a valid word, then stays busy for busy_len cycles.
    logic tx_auto = 1'b1;
    int   busy_len = 10;
    logic auto_busy;
    int   busy_left;
    logic [DW-1:0] delivered [$];
    assign tx_busy = auto_busy;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            auto_busy <= 1'b0;
            busy_left <= 0;
        end else if (tx_auto && tx_valid && !tx_busy) begin
            auto_busy <= 1'b1;
            busy_left <= busy_len - 1;
            delivered.push_back(tx_data);
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
        end else begin
            auto_busy <= 1'b0;
        end
    end

    int pops = 0;
    int valid_cycles = 0;
    always @(posedge CLK) begin
        if (R_inc) pops <= pops + 1;
        if (tx_valid) valid_cycles <= valid_cycles + 1;
    end

    // Reference: a word is "on offer" from the cycle after its pop until the
    // transmitter takes it or it has been offered TO cycles; a taken word counts
    // once the transmitter goes idle again.
    logic          m_offer, m_in_frame, m_err;
    logic [DW-1:0] m_data;
    logic [CW-1:0] m_cnt;
    int            m_age;
    logic          exp_pop;
    assign exp_pop = !RST && enable && !empty && !tx_busy && !m_offer && !m_in_frame;

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_offer <= 1'b0; m_in_frame <= 1'b0; m_err <= 1'b0;
            m_data <= '0; m_cnt <= '0; m_age <= 0;
        end else if (m_in_frame) begin
            if (!tx_busy) begin
                m_in_frame <= 1'b0;
                m_cnt <= CW'((int'(m_cnt) + 1) % (1 << CW));
            end
        end else if (m_offer) begin
            if (tx_busy) begin
                m_offer <= 1'b0;
                m_in_frame <= 1'b1;
            end else if (m_age >= TO) begin
                m_offer <= 1'b0;
                m_err <= 1'b1;
            end else begin
                m_age <= m_age + 1;
            end
        end else if (exp_pop) begin
            m_offer <= 1'b1;
            m_data <= R_data;
            m_age <= 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("R_inc", 32'(R_inc), 32'(exp_pop));
        chk("tx_valid", 32'(tx_valid), 32'(m_offer));
        chk("tx_data", 32'(tx_data), 32'(m_data));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        chk("byte_cnt", 32'(byte_cnt), 32'(m_cnt));
    end

    task automatic push(input logic [DW-1:0] v);
        fifo_mem[wr_ptr[5:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_cnt(input int target, input int budget, input string name);
        int n = 0;
        while (int'(byte_cnt) != target && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(byte_cnt), 32'(target));
        $display("txn %s: byte_cnt=%0d after %0d cycles", name, byte_cnt, n);
    endtask

    initial begin
        int p0, v0, n;
        repeat (3) tick();
        RST = 1'b0;
        tick();
        chk("reset tx_valid", 32'(tx_valid), 0);
        chk("reset tx_data", 32'(tx_data), 0);
        chk("reset byte_cnt", 32'(byte_cnt), 0);
        chk("reset timeout_err", 32'(timeout_err), 0);

        // Empty FIFO with enable high: nothing happens.
        enable = 1'b1;
        repeat (20) tick();
        chk("empty pops", 32'(pops), 0);
        $display("txn idle: pops=%0d", pops);

        // Single word.
        push(8'hA5);
        wait_cnt(1, 60, "single cnt");
        chk("single pops", 32'(pops), 1);
        chk("single word", 32'(delivered[0]), 32'h0A5);

        // Three queued words delivered in order.
        push(8'h11); push(8'h22); push(8'h33);
        wait_cnt(4, 200, "burst cnt");
        chk("burst pops", 32'(pops), 4);
        chk("burst w0", 32'(delivered[1]), 32'h11);
        chk("burst w1", 32'(delivered[2]), 32'h22);
        chk("burst w2", 32'(delivered[3]), 32'h33);

        // Transmitter never answers: watchdog drops 0x77, next word pops at once.
        tx_auto = 1'b0;
        v0 = valid_cycles;
        push(8'h77); push(8'h88);
        n = 0;
        while (!timeout_err && n < 100) begin tick(); n++; end
        chk("timeout flag", 32'(timeout_err), 1);
        chk("timeout valid cycles", 32'(valid_cycles - v0), TO);
        chk("timeout next pop", 32'(R_inc), 1);
        $display("txn timeout: valid for %0d cycles", valid_cycles - v0);
        tx_auto = 1'b1;
        wait_cnt(5, 60, "after timeout cnt");
        chk("after timeout word", 32'(delivered[4]), 32'h88);
        chk("timeout sticky", 32'(timeout_err), 1);

        // Drop enable while a frame is in progress.
        push(8'h44); push(8'h55);
        n = 0;
        while (!(tx_busy && delivered.size() == 6) && n < 60) begin tick(); n++; end
        tick();
        enable = 1'b0;
        p0 = pops;
        wait_cnt(6, 60, "disable cnt");
        repeat (20) tick();
        chk("disabled no pop", 32'(pops - p0), 0);
        enable = 1'b1;
        wait_cnt(7, 60, "reenable cnt");
        chk("reenable word", 32'(delivered[6]), 32'h55);

        // Asynchronous reset while a word is on offer.
        push(8'h5A);
        n = 0;
        while (!tx_valid && n < 20) begin tick(); n++; end
        chk("pre-reset data", 32'(tx_data), 32'h5A);
        #2 RST = 1'b1;
        #1;
        chk("async tx_valid", 32'(tx_valid), 0);
        chk("async tx_data", 32'(tx_data), 0);
        chk("async byte_cnt", 32'(byte_cnt), 0);
        chk("async timeout_err", 32'(timeout_err), 0);
        $display("txn async reset: tx_valid=%0d tx_data=%0h", tx_valid, tx_data);
        tick(); tick();
        RST = 1'b0;

        // 17 words wrap a 4-bit counter to 1.
        busy_len = 3;
        for (int i = 0; i < 17; i++) push(DW'(i * 3 + 1));
        n = 0;
        while (delivered.size() < 24 && n < 1000) begin tick(); n++; end
        wait_cnt(1, 40, "wrap cnt");
        chk("wrap delivered", 32'(delivered.size()), 24);
        chk("post-reset first word", 32'(delivered[7]), 32'h01);
        chk("wrap last word", 32'(delivered[23]), 32'd49);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
